// File: rtl/ow_cmd_master_if.sv
// Command/response and 1-Wire pad bundle between an SPI front end and ow_cmd_master.
`default_nettype none

interface ow_cmd_master_if;
  logic [15:0] CMD;
  logic        CMD_VALID;
  logic        OW_IN;
  logic        OW_PULL;
  logic [7:0]  RESP;
  logic        BUSY;
  logic        DONE;

  modport master (
    output CMD, CMD_VALID, OW_IN,
    input  OW_PULL, RESP, BUSY, DONE
  );

  modport slave (
    input  CMD, CMD_VALID, OW_IN,
    output OW_PULL, RESP, BUSY, DONE
  );
endinterface

`default_nettype wire

// File: rtl/ow_cmd_master.sv
// ow_cmd_master: 1-Wire reset/write/read/status engine driven by 16-bit commands.
// Optional Dallas CRC-8 accumulator and opcodes 0x04/0x05 enabled by macro OW_CRC8_EN.
`default_nettype none

module ow_cmd_master #(
  parameter int CLK_DIV_US = 50
) (
  input  logic          CLK,
  input  logic          RST,
  ow_cmd_master_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RST_LOW   = 3'd1,
    RST_WAIT  = 3'd2,
    SLOT_LOW  = 3'd3,
    SLOT_HOLD = 3'd4,
    SLOT_REC  = 3'd5
  } state_t;

  localparam logic [7:0] PRSC_MAX       = 8'(CLK_DIV_US - 1);
  localparam logic [9:0] RST_PHASE_LAST = 10'd479;
  localparam logic [9:0] PRES_SAMPLE_US = 10'd69;
  localparam logic [9:0] LOW_SHORT_LAST = 10'd5;
  localparam logic [9:0] LOW_LONG_LAST  = 10'd59;
  localparam logic [9:0] HOLD_RD_LAST   = 10'd8;
  localparam logic [9:0] REC_RD_LAST    = 10'd54;
  localparam logic [9:0] REC_W1_LAST    = 10'd63;
  localparam logic [9:0] REC_W0_LAST    = 10'd9;

  localparam logic [7:0] OP_STATUS  = 8'h00;
  localparam logic [7:0] OP_RESET   = 8'h01;
  localparam logic [7:0] OP_WRITE   = 8'h02;
  localparam logic [7:0] OP_READ    = 8'h03;
`ifdef OW_CRC8_EN
  localparam logic [7:0] OP_CRC_RD  = 8'h04;
  localparam logic [7:0] OP_CRC_CLR = 8'h05;
`endif

  state_t      state_q;
  logic [1:0]  sync_q;
  logic [7:0]  prsc_q;
  logic [9:0]  us_q;
  logic [2:0]  bit_q;
  logic [7:0]  op_q;
  logic [7:0]  data_q;
  logic [7:0]  shift_q;
  logic        pull_q;
  logic        busy_q;
  logic        done_q;
  logic [7:0]  resp_q;
  logic        ovr_q;
  logic        pres_q;
`ifdef OW_CRC8_EN
  logic [7:0]  crc_q;

  function automatic logic [7:0] crc_bit(input logic [7:0] crc, input logic b);
    logic fb;
    fb = crc[0] ^ b;
    crc_bit = {1'b0, crc[7:1]} ^ (fb ? 8'h8C : 8'h00);
  endfunction
`endif

  logic       tick;
  logic       ow_s;
  logic       is_read;
  logic [9:0] lim_us;

  assign tick    = (prsc_q == PRSC_MAX);
  assign ow_s    = sync_q[1];
  assign is_read = (op_q == OP_READ);

  // Last microsecond index of the current phase; shift_q[0] is the bit being written.
  always_comb begin
    lim_us = '0;
    case (state_q)
      RST_LOW, RST_WAIT: lim_us = RST_PHASE_LAST;
      SLOT_LOW:  lim_us = (is_read || shift_q[0]) ? LOW_SHORT_LAST : LOW_LONG_LAST;
      SLOT_HOLD: lim_us = HOLD_RD_LAST;
      SLOT_REC:  lim_us = is_read ? REC_RD_LAST : (shift_q[0] ? REC_W1_LAST : REC_W0_LAST);
      default:   lim_us = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      sync_q  <= '0;
      prsc_q  <= '0;
      us_q    <= '0;
      bit_q   <= '0;
      op_q    <= '0;
      data_q  <= '0;
      shift_q <= '0;
      pull_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      resp_q  <= '0;
      ovr_q   <= 1'b0;
      pres_q  <= 1'b0;
`ifdef OW_CRC8_EN
      crc_q   <= '0;
`endif
    end else begin
      sync_q <= {sync_q[0], bus.OW_IN};
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        prsc_q <= '0;
        us_q   <= '0;
        // The DONE cycle still counts as part of the finishing command.
        if (bus.CMD_VALID && !done_q) begin
          op_q    <= bus.CMD[15:8];
          data_q  <= bus.CMD[7:0];
          shift_q <= bus.CMD[7:0];
          bit_q   <= '0;
          case (bus.CMD[15:8])
            OP_RESET: begin
              state_q <= RST_LOW;
              pull_q  <= 1'b1;
              busy_q  <= 1'b1;
            end
            OP_WRITE, OP_READ: begin
              state_q <= SLOT_LOW;
              pull_q  <= 1'b1;
              busy_q  <= 1'b1;
            end
            OP_STATUS: begin
              resp_q <= {ovr_q, 6'b0, pres_q};
              ovr_q  <= 1'b0;
              done_q <= 1'b1;
            end
`ifdef OW_CRC8_EN
            OP_CRC_RD: begin
              resp_q <= crc_q;
              done_q <= 1'b1;
            end
            OP_CRC_CLR: begin
              crc_q  <= '0;
              resp_q <= '0;
              done_q <= 1'b1;
            end
`endif
            default: begin
              resp_q <= 8'hFF;
              done_q <= 1'b1;
            end
          endcase
        end else if (bus.CMD_VALID) begin
          ovr_q <= 1'b1;
        end
      end else begin
        if (bus.CMD_VALID) ovr_q <= 1'b1;
        if (!tick) begin
          prsc_q <= prsc_q + 8'd1;
        end else begin
          prsc_q <= '0;
          us_q   <= (us_q == lim_us) ? 10'd0 : us_q + 10'd1;
          if (state_q == RST_WAIT && us_q == PRES_SAMPLE_US) pres_q <= ~ow_s;
          if (us_q == lim_us) begin
            case (state_q)
              RST_LOW: begin
                state_q <= RST_WAIT;
                pull_q  <= 1'b0;
              end
              RST_WAIT: begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                resp_q  <= {7'b0, pres_q};
              end
              SLOT_LOW: begin
                pull_q  <= 1'b0;
                state_q <= is_read ? SLOT_HOLD : SLOT_REC;
              end
              SLOT_HOLD: begin
                shift_q <= {ow_s, shift_q[7:1]};
`ifdef OW_CRC8_EN
                crc_q   <= crc_bit(crc_q, ow_s);
`endif
                state_q <= SLOT_REC;
              end
              SLOT_REC: begin
                bit_q <= bit_q + 3'd1;
                if (!is_read) begin
                  shift_q <= {1'b0, shift_q[7:1]};
`ifdef OW_CRC8_EN
                  crc_q   <= crc_bit(crc_q, shift_q[0]);
`endif
                end
                if (bit_q == 3'd7) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  resp_q  <= is_read ? shift_q : data_q;
                end else begin
                  state_q <= SLOT_LOW;
                  pull_q  <= 1'b1;
                end
              end
              default: state_q <= IDLE;
            endcase
          end
        end
      end
    end
  end

  assign bus.OW_PULL = pull_q;
  assign bus.RESP    = resp_q;
  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_ow_cmd_master.sv
// Bench for ow_cmd_master: bus/device model, randomized bytes, reference model of responses and timing.
`default_nettype none

module tb_ow_cmd_master;

  localparam int DIV = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  ow_cmd_master_if bus ();

  ow_cmd_master #(.CLK_DIV_US(DIV)) u_dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Open-drain bus with an optional slave device.
  logic       dev_pull = 1'b0;
  logic       dev_present = 1'b0;
  bit         rd_active = 1'b0;
  logic [7:0] rd_byte = 8'h00;
  int         rd_idx = 0;
  int         cyc = 0;
  int         low_start = 0;
  int         dev_from = 0;
  int         dev_to = 0;
  int         done_cnt = 0;
  logic       pull_prev = 1'b0;
  int         pulses[$];

  assign bus.OW_IN = ~(bus.OW_PULL | dev_pull);

  always @(posedge CLK) begin
    int len;
    if (bus.DONE === 1'b1) done_cnt++;
    if (bus.OW_PULL === 1'b1 && pull_prev === 1'b0) low_start = cyc;
    if (bus.OW_PULL === 1'b0 && pull_prev === 1'b1) begin
      len = cyc - low_start;
      pulses.push_back(len);
      if (len >= 1800 && dev_present) begin
        dev_from = cyc + 20 * DIV;
        dev_to   = cyc + 140 * DIV;
      end else if (len < 100 && rd_active) begin
        if (rd_byte[rd_idx % 8] == 1'b0) begin
          dev_from = cyc;
          dev_to   = cyc + 30 * DIV;
        end
        rd_idx++;
      end
    end
    pull_prev = bus.OW_PULL;
    dev_pull <= (cyc >= dev_from) && (cyc < dev_to);
    cyc = cyc + 1;
  end

  // Reference state
  logic       exp_ovr = 1'b0;
  logic       exp_pres = 1'b0;
  logic [7:0] exp_crc = 8'h00;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if ((c[0] ^ b[i]) == 1'b1) c = (c >> 1) ^ 8'h8C;
      else c = c >> 1;
    end
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [15:0] c);
    @(negedge CLK);
    bus.CMD = c;
    bus.CMD_VALID = 1'b1;
    @(posedge CLK);
    #1;
    bus.CMD_VALID = 1'b0;
  endtask

  // Issue a command, wait for DONE, check response and latency window.
  task automatic do_cmd(input string tag, input logic [15:0] c, input logic [7:0] exp_resp,
                        input int lat_min, input int lat_max, input int poke_mid, input bit poke_done);
    int lat;
    pulses.delete();
    issue(c);
    lat = 0;
    while (bus.DONE !== 1'b1 && lat < 5000) begin
      @(posedge CLK);
      #1;
      lat++;
      if (bus.CMD_VALID === 1'b1) bus.CMD_VALID = 1'b0;
      if (lat == poke_mid) begin
        bus.CMD = 16'h0100;
        bus.CMD_VALID = 1'b1;
      end
    end
    check({tag, "_done"}, bus.DONE, 1'b1);
    check({tag, "_busy_at_done"}, bus.BUSY, 1'b0);
    check({tag, "_resp"}, bus.RESP, exp_resp);
    check({tag, "_lat_ok"}, (lat >= lat_min && lat <= lat_max), 1'b1);
    if (poke_done) begin
      bus.CMD = 16'h0100;
      bus.CMD_VALID = 1'b1;
    end
    @(posedge CLK);
    #1;
    bus.CMD_VALID = 1'b0;
    check({tag, "_done_pulse"}, bus.DONE, 1'b0);
    check({tag, "_resp_hold"}, bus.RESP, exp_resp);
    @(posedge CLK);
    #1;
    check({tag, "_idle_busy"}, bus.BUSY, 1'b0);
    check({tag, "_idle_pull"}, bus.OW_PULL, 1'b0);
  endtask

  task automatic check_write_pulses(input string tag, input logic [7:0] b);
    check({tag, "_npulses"}, pulses.size(), 8);
    for (int i = 0; i < 8 && i < pulses.size(); i++)
      check({tag, "_pulse"}, pulses[i], b[i] ? 6 * DIV : 60 * DIV);
  endtask

  task automatic status(input string tag);
    do_cmd(tag, 16'h0000, {exp_ovr, 6'b0, exp_pres}, 0, 0, -1, 0);
    exp_ovr = 1'b0;
  endtask

  task automatic read_byte(input string tag, input logic [7:0] b, input int poke_mid);
    rd_byte = b;
    rd_idx = 0;
    rd_active = 1'b1;
    do_cmd(tag, 16'h0300, b, 70 * 8 * DIV, 70 * 8 * DIV, poke_mid, 0);
    rd_active = 1'b0;
    check({tag, "_npulses"}, pulses.size(), 8);
    for (int i = 0; i < 8 && i < pulses.size(); i++)
      check({tag, "_pulse"}, pulses[i], 6 * DIV);
    exp_crc = crc8_byte(exp_crc, b);
  endtask

  task automatic write_byte(input string tag, input logic [7:0] b, input bit poke_done);
    do_cmd(tag, {8'h02, b}, b, 70 * 8 * DIV, 70 * 8 * DIV, -1, poke_done);
    check_write_pulses(tag, b);
    exp_crc = crc8_byte(exp_crc, b);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] seq[7];
    int dc;
    bus.CMD = 16'h0000;
    bus.CMD_VALID = 1'b0;

    repeat (5) @(posedge CLK);
    #1;
    check("rst_pull", bus.OW_PULL, 1'b0);
    check("rst_busy", bus.BUSY, 1'b0);
    check("rst_done", bus.DONE, 1'b0);
    check("rst_resp", bus.RESP, 8'h00);
    @(negedge CLK);
    RST = 1'b0;

    dev_present = 1'b1;
    do_cmd("busrst_dev", 16'h0100, 8'h01, 960 * DIV - 2, 960 * DIV + 2, -1, 0);
    exp_pres = 1'b1;
    check("busrst_npulses", pulses.size(), 1);
    if (pulses.size() > 0) check("busrst_low", pulses[0], 480 * DIV);
    status("stat_pres");

    dev_present = 1'b0;
    do_cmd("busrst_nodev", 16'h0100, 8'h00, 960 * DIV - 2, 960 * DIV + 2, -1, 0);
    exp_pres = 1'b0;
    status("stat_nopres");

    write_byte("wr_a5", 8'hA5, 0);
    for (int i = 0; i < 3; i++) write_byte("wr_rand", 8'($urandom_range(255, 0)), 0);

    read_byte("rd_3c", 8'h3C, -1);
    for (int i = 0; i < 3; i++) read_byte("rd_rand", 8'($urandom_range(255, 0)), -1);

    read_byte("rd_ovr", 8'($urandom_range(255, 0)), 1000);
    exp_ovr = 1'b1;
    status("stat_ovr_set");
    status("stat_ovr_clr");

    write_byte("wr_pokedone", 8'($urandom_range(255, 0)), 1);
    exp_ovr = 1'b1;
    status("stat_pokedone_set");
    status("stat_pokedone_clr");

    for (int i = 0; i < 4; i++) begin
      op = 8'($urandom_range(255, 6));
      b = 8'($urandom_range(255, 0));
      do_cmd("unknown_op", {op, b}, 8'hFF, 0, 0, -1, 0);
    end

`ifdef OW_CRC8_EN
    do_cmd("crc_running", 16'h0400, exp_crc, 0, 0, -1, 0);
    do_cmd("crc_clear", 16'h0500, 8'h00, 0, 0, -1, 0);
    exp_crc = 8'h00;
    seq = '{8'h02, 8'h1C, 8'hB8, 8'h01, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 7; i++) read_byte("crc_rd", seq[i], -1);
    do_cmd("crc_rom", 16'h0400, 8'hA2, 0, 0, -1, 0);
`else
    seq = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    do_cmd("crc_rd_absent", {8'h04, seq[0]}, 8'hFF, 0, 0, -1, 0);
    do_cmd("crc_clr_absent", 16'h0500, 8'hFF, 0, 0, -1, 0);
`endif

    // Abort a bus reset 100 us into its low phase.
    dev_present = 1'b1;
    issue(16'h0100);
    check("abort_pull_before", bus.OW_PULL, 1'b1);
    repeat (100 * DIV - 1) @(posedge CLK);
    #1;
    RST = 1'b1;
    dc = done_cnt;
    @(posedge CLK);
    #1;
    check("abort_pull", bus.OW_PULL, 1'b0);
    check("abort_busy", bus.BUSY, 1'b0);
    check("abort_done", bus.DONE, 1'b0);
    check("abort_resp", bus.RESP, 8'h00);
    RST = 1'b0;
    exp_ovr = 1'b0;
    exp_pres = 1'b0;
    exp_crc = 8'h00;
    repeat (1000 * DIV) @(posedge CLK);
    #1;
    check("abort_no_done", done_cnt, dc);
    check("abort_idle_busy", bus.BUSY, 1'b0);
    status("stat_after_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
